// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache miss ports and shared RAM port bundled for the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dwait;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramready;
  logic [1:0]        owner;
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, owner
  );
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache/dcache word accesses onto one RAM port, data first with bounded starvation
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;
  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       dreq;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
  // completions are suppressed while reset is asserted so no wait pulse escapes
  always_comb begin
    dreq         = bus.dREN | bus.dWEN;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    bus.iload    = '0;
    bus.iwait    = 1'b1;
    bus.dload    = '0;
    bus.dwait    = 1'b1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.owner    = 2'b00;
    case (state_q)
      IDLE: begin
        if (dreq && (!bus.iREN || starve_cnt_q < 4'(STARVE_MAX))) begin
          state_d      = D_ACC;
          starve_cnt_d = bus.iREN ? starve_cnt_q + {3'b0, starve_cnt_q != 4'hf} : starve_cnt_q;
        end else begin
          state_d      = bus.iREN ? I_ACC : IDLE;
          starve_cnt_d = '0;
        end
      end
      I_ACC: begin
        bus.owner   = 2'b01;
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = !(bus.iREN && bus.ramready && nRST);
        bus.iload   = !bus.iwait ? bus.ramload : '0;
        state_d     = (!bus.iREN || bus.ramready) ? IDLE : I_ACC;
      end
      D_ACC: begin
        bus.owner    = 2'b10;
        bus.ramREN   = bus.dREN & !bus.dWEN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dwait    = !(dreq && bus.ramready && nRST);
        bus.dload    = (!bus.dwait && !bus.dWEN) ? bus.ramload : '0;
        state_d      = (!dreq || bus.ramready) ? IDLE : D_ACC;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [5:0] ctl;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.STARVE_MAX(4)) dut (.CLK(clk), .nRST(n_rst), .bus(bus));
  // packed view {owner, iwait, dwait, ramREN, ramWEN}
  assign ctl = {bus.owner, bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN};
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramready = 0;
  endtask
  task automatic test_reset();
    clear();
    n_rst = 0;
    cyc(); cyc();
    @(negedge clk);
    checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 6'b001100); end
    checks++; if ({bus.iload, bus.dload, bus.ramaddr, bus.ramstore} !== 128'h0) begin errors++; $display("FAIL reset_data got %h %h %h %h exp 0", bus.iload, bus.dload, bus.ramaddr, bus.ramstore); end
    checks++; if (dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", dut.starve_cnt_q); end
    n_rst = 1;
    cyc();
  endtask
  task automatic test_ifetch();
    bus.iREN = 1; bus.iaddr = 32'h40;
    @(negedge clk);
    checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL ifetch_c0 got %b exp %b", ctl, 6'b001100); end
    cyc(); @(negedge clk);
    checks++; if (ctl !== 6'b011110 || bus.ramaddr !== 32'h40) begin errors++; $display("FAIL ifetch_c1 got %b %h exp %b 40", ctl, bus.ramaddr, 6'b011110); end
    cyc(); @(negedge clk);
    checks++; if (ctl !== 6'b011110) begin errors++; $display("FAIL ifetch_c2 got %b exp %b", ctl, 6'b011110); end
    cyc();
    bus.ramready = 1; bus.ramload = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (ctl !== 6'b010110 || bus.iload !== 32'hDEADBEEF || bus.dload !== 32'h0) begin errors++; $display("FAIL ifetch_c3 got %b %h %h exp %b deadbeef 0", ctl, bus.iload, bus.dload, 6'b010110); end
    cyc();
    bus.iREN = 0; bus.ramready = 0;
    @(negedge clk);
    checks++; if (ctl !== 6'b001100 || bus.iload !== 32'h0) begin errors++; $display("FAIL ifetch_c4 got %b %h exp %b 0", ctl, bus.iload, 6'b001100); end
    cyc();
  endtask
  task automatic test_dwrite();
    bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'h12345678; bus.ramready = 1; bus.ramload = 32'hAAAA5555;
    @(negedge clk);
    checks++; if (ctl !== 6'b001100 || bus.ramstore !== 32'h0) begin errors++; $display("FAIL dwrite_c0 got %b %h exp %b 0", ctl, bus.ramstore, 6'b001100); end
    cyc(); @(negedge clk);
    checks++; if (ctl !== 6'b101001) begin errors++; $display("FAIL dwrite_ctl got %b exp %b", ctl, 6'b101001); end
    checks++; if (bus.ramaddr !== 32'h100 || bus.ramstore !== 32'h12345678) begin errors++; $display("FAIL dwrite_bus got %h %h exp 100 12345678", bus.ramaddr, bus.ramstore); end
    checks++; if (bus.dload !== 32'h0 || bus.iload !== 32'h0) begin errors++; $display("FAIL dwrite_load got %h %h exp 0 0", bus.dload, bus.iload); end
    cyc();
    clear();
    @(negedge clk);
    checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL dwrite_c2 got %b exp %b", ctl, 6'b001100); end
    cyc();
  endtask
  task automatic test_both_en();
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h55;
    cyc(); @(negedge clk);
    checks++; if (ctl !== 6'b101101) begin errors++; $display("FAIL both_wait got %b exp %b", ctl, 6'b101101); end
    cyc();
    bus.ramready = 1; bus.ramload = 32'h99;
    @(negedge clk);
    checks++; if (ctl !== 6'b101001 || bus.dload !== 32'h0) begin errors++; $display("FAIL both_done got %b %h exp %b 0", ctl, bus.dload, 6'b101001); end
    cyc();
    clear();
    @(negedge clk);
    checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL both_after got %b exp %b", ctl, 6'b001100); end
    cyc();
  endtask
  task automatic test_starve();
    logic [1:0] exp_own [13] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
    bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h44; bus.daddr = 32'h300; bus.ramready = 1; bus.ramload = 32'h5A5A;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      checks++; if (bus.owner !== exp_own[i]) begin errors++; $display("FAIL starve_owner[%0d] got %0d exp %0d", i, bus.owner, exp_own[i]); end
      cyc();
    end
    clear();
    cyc(); cyc();
  endtask
  task automatic test_abort();
    bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h48; bus.daddr = 32'h400;
    cyc(); @(negedge clk);
    checks++; if (ctl !== 6'b101110) begin errors++; $display("FAIL abort_grant got %b exp %b", ctl, 6'b101110); end
    cyc();
    bus.dREN = 0; bus.ramready = 1; bus.ramload = 32'h77;
    @(negedge clk);
    checks++; if (ctl !== 6'b101100 || bus.dload !== 32'h0) begin errors++; $display("FAIL abort_drop got %b %h exp %b 0", ctl, bus.dload, 6'b101100); end
    cyc();
    bus.ramready = 0;
    @(negedge clk);
    checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL abort_idle got %b exp %b", ctl, 6'b001100); end
    cyc();
    bus.ramready = 1; bus.ramload = 32'h1234;
    @(negedge clk);
    checks++; if (ctl !== 6'b010110 || bus.iload !== 32'h1234 || bus.ramaddr !== 32'h48) begin errors++; $display("FAIL abort_ifetch got %b %h %h exp %b 1234 48", ctl, bus.iload, bus.ramaddr, 6'b010110); end
    cyc();
    clear();
    @(negedge clk);
    checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL abort_after got %b exp %b", ctl, 6'b001100); end
    cyc();
  endtask
  task automatic test_reset_mid();
    bus.iREN = 1; bus.iaddr = 32'h80;
    cyc(); @(negedge clk);
    checks++; if (ctl !== 6'b011110) begin errors++; $display("FAIL rstmid_iacc got %b exp %b", ctl, 6'b011110); end
    n_rst = 0;
    cyc(); @(negedge clk);
    checks++; if (ctl !== 6'b001100 || dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL rstmid_i got %b cnt %0d exp %b cnt 0", ctl, dut.starve_cnt_q, 6'b001100); end
    n_rst = 1; clear();
    cyc();
    bus.iREN = 1; bus.dREN = 1;
    cyc(); @(negedge clk);
    checks++; if (ctl !== 6'b101110 || dut.starve_cnt_q !== 4'd1) begin errors++; $display("FAIL rstmid_dacc got %b cnt %0d exp %b cnt 1", ctl, dut.starve_cnt_q, 6'b101110); end
    n_rst = 0;
    cyc(); @(negedge clk);
    checks++; if (ctl !== 6'b001100 || dut.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL rstmid_d got %b cnt %0d exp %b cnt 0", ctl, dut.starve_cnt_q, 6'b001100); end
    n_rst = 1; clear();
    cyc();
  endtask
  initial begin
    test_reset();
    test_ifetch();
    test_dwrite();
    test_both_en();
    test_starve();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
